// File: rtl/divide_block_if.sv
// divide_block_if -- request/result bundle for divide_block.
//   start            : request pulse (master -> slave)
//   A, B             : unsigned dividend / divisor (master -> slave)
//   busy, done       : operation in progress / one-cycle result strobe (slave -> master)
//   quotient         : registered A / B (slave -> master)
//   remainder        : registered A mod B (slave -> master)
//   div_zero         : divisor-was-zero flag, only with MATH_DIV_ZERO_CHECK_EN (slave -> master)
interface divide_block_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

`ifdef MATH_DIV_ZERO_CHECK_EN
   logic             div_zero;

   modport master (output start, A, B,
                   input  busy, done, quotient, remainder, div_zero);
   modport slave  (input  start, A, B,
                   output busy, done, quotient, remainder, div_zero);
`else
   modport master (output start, A, B,
                   input  busy, done, quotient, remainder);
   modport slave  (input  start, A, B,
                   output busy, done, quotient, remainder);
`endif
endinterface

// File: rtl/divide_block.sv
// divide_block -- sequential restoring divider, one quotient bit per RUN cycle.
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : divide_block_if.slave (start, A, B in; busy, done, quotient, remainder out)
// Optional: define MATH_DIV_ZERO_CHECK_EN to short-circuit B=0 and add the div_zero output.
// Timing: start accepted at edge N -> done high after edge N+WIDTH+1, busy low after N+WIDTH+2.
module divide_block #(
   parameter int unsigned WIDTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   divide_block_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   // Partial remainder: its top bit is provably zero after every step, so only WIDTH bits are kept.
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] d_q;
   logic [CntW-1:0]  cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;

   // One restoring step, WIDTH+1 bits wide.
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;
   logic           fits;

   always_comb begin
      trial = {r_q, q_q[WIDTH-1]};
      diff  = trial - {1'b0, d_q};
      fits  = (trial >= {1'b0, d_q});
   end

`ifdef MATH_DIV_ZERO_CHECK_EN
   logic dz_q;
   logic dz_out_q;
   assign bus.div_zero = dz_out_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         q_q      <= '0;
         r_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         quot_q   <= '0;
         rem_q    <= '0;
`ifdef MATH_DIV_ZERO_CHECK_EN
         dz_q     <= 1'b0;
         dz_out_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
                  q_q     <= bus.A;
                  r_q     <= '0;
                  d_q     <= bus.B;
                  cnt_q   <= '0;
`ifdef MATH_DIV_ZERO_CHECK_EN
                  dz_q    <= (bus.B == '0);
                  // Zero divisor: preload the final result so the next edge enters DONE.
                  if (bus.B == '0) begin
                     q_q   <= '1;
                     r_q   <= bus.A;
                     cnt_q <= LastCnt;
                  end
`endif
               end
            end
            StRun: begin
               if (cnt_q == LastCnt) begin
                  state_q  <= StDone;
                  done_q   <= 1'b1;
                  quot_q   <= q_q;
                  rem_q    <= r_q;
`ifdef MATH_DIV_ZERO_CHECK_EN
                  dz_out_q <= dz_q;
`endif
               end else begin
                  r_q   <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                  q_q   <= {q_q[WIDTH-2:0], fits};
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;

endmodule

// File: tb/tb_divide_block.sv
module tb_divide_block;

   localparam int unsigned W = 4;
`ifdef MATH_DIV_ZERO_CHECK_EN
   localparam int DzLat = 1;
`else
   localparam int DzLat = W + 1;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   divide_block_if #(.WIDTH(W)) bus ();

   divide_block #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a request at the negedge; returns #1 after the accepting edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Number of edges after the accepting edge until done is seen; -1 on timeout.
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_checks++; if (bus.quotient !== 4'd0) begin n_fail++; $display("FAIL reset_quot: got %0d want 0", bus.quotient); end
      n_checks++; if (bus.remainder !== 4'd0) begin n_fail++; $display("FAIL reset_rem: got %0d want 0", bus.remainder); end
`ifdef MATH_DIV_ZERO_CHECK_EN
      n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", bus.div_zero); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // 13 / 4 with full timing of busy and done.
   task automatic test_basic();
      int n;
      launch(4'd13, 4'd4);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_run: got %b want 1", bus.busy); end
      wait_done(n);
      n_checks++; if (n != 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", n); end
      n_checks++; if (bus.quotient !== 4'd3) begin n_fail++; $display("FAIL basic_quot: got %0d want 3", bus.quotient); end
      n_checks++; if (bus.remainder !== 4'd1) begin n_fail++; $display("FAIL basic_rem: got %0d want 1", bus.remainder); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: got %b want 1", bus.busy); end
      @(posedge clk);
      #1;
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle: got %b want 0", bus.busy); end
      n_checks++; if (bus.quotient !== 4'd3) begin n_fail++; $display("FAIL basic_quot_hold: got %0d want 3", bus.quotient); end
   endtask

   // {A, B, quotient, remainder}
   task automatic test_vectors();
      int tab[6][4] = '{'{15, 1, 15, 0}, '{6, 9, 0, 6}, '{0, 7, 0, 0}, '{7, 0, 15, 7},
                        '{11, 11, 1, 0}, '{14, 5, 2, 4}};
      int n;
      int lat;
      for (int k = 0; k < 6; k++) begin
         launch(tab[k][0][W-1:0], tab[k][1][W-1:0]);
         wait_done(n);
         lat = (tab[k][1] == 0) ? DzLat : W + 1;
         n_checks++; if (n != lat) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want %0d", k, n, lat); end
         n_checks++; if (bus.quotient !== tab[k][2][W-1:0]) begin n_fail++; $display("FAIL vec%0d_quot: got %0d want %0d", k, bus.quotient, tab[k][2]); end
         n_checks++; if (bus.remainder !== tab[k][3][W-1:0]) begin n_fail++; $display("FAIL vec%0d_rem: got %0d want %0d", k, bus.remainder, tab[k][3]); end
`ifdef MATH_DIV_ZERO_CHECK_EN
         n_checks++; if (bus.div_zero !== (tab[k][1] == 0)) begin n_fail++; $display("FAIL vec%0d_dz: got %b want %b", k, bus.div_zero, tab[k][1] == 0); end
`endif
         settle();
`ifdef MATH_DIV_ZERO_CHECK_EN
         n_checks++; if (bus.div_zero !== (tab[k][1] == 0)) begin n_fail++; $display("FAIL vec%0d_dz_hold: got %b want %b", k, bus.div_zero, tab[k][1] == 0); end
`endif
      end
   endtask

   // Second start during RUN and A/B changes are ignored; results hold during RUN.
   task automatic test_ignore_start();
      int pulses;
      logic [W-1:0] q_seen;
      logic [W-1:0] r_seen;
      pulses = 0;
      q_seen = '0;
      r_seen = '0;
      launch(4'd9, 4'd2);
      @(posedge clk);
      launch(4'd15, 4'd3);
      n_checks++; if (bus.quotient !== 4'd2) begin n_fail++; $display("FAIL ign_quot_hold_run: got %0d want 2", bus.quotient); end
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            pulses++;
            q_seen = bus.quotient;
            r_seen = bus.remainder;
         end
      end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
      n_checks++; if (q_seen !== 4'd4) begin n_fail++; $display("FAIL ign_quot: got %0d want 4", q_seen); end
      n_checks++; if (r_seen !== 4'd1) begin n_fail++; $display("FAIL ign_rem: got %0d want 1", r_seen); end
   endtask

   task automatic test_reset_midrun();
      int pulses;
      int n;
      pulses = 0;
      launch(4'd14, 4'd3);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.quotient !== 4'd0) begin n_fail++; $display("FAIL mid_quot: got %0d want 0", bus.quotient); end
      n_checks++; if (bus.remainder !== 4'd0) begin n_fail++; $display("FAIL mid_rem: got %0d want 0", bus.remainder); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) pulses++;
      end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d active cycles want 0", pulses); end
      // Start presented at the same negedge as reset release: accepted on the first edge.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      bus.start = 1'b1;
      bus.A     = 4'd14;
      bus.B     = 4'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(n);
      n_checks++; if (n != 5) begin n_fail++; $display("FAIL rel_latency: got %0d want 5", n); end
      n_checks++; if (bus.quotient !== 4'd4) begin n_fail++; $display("FAIL rel_quot: got %0d want 4", bus.quotient); end
      n_checks++; if (bus.remainder !== 4'd2) begin n_fail++; $display("FAIL rel_rem: got %0d want 2", bus.remainder); end
      settle();
   endtask

   task automatic test_back_to_back();
      int edges[$];
      int bad;
      bad = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 4'd13;
      bus.B     = 4'd4;
      for (int e = 1; e <= 28; e++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            edges.push_back(e);
            if (bus.quotient !== 4'd3 || bus.remainder !== 4'd1) bad++;
         end
      end
      bus.start = 1'b0;
      n_checks++; if (edges.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", edges.size()); end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_results: got %0d wrong want 0", bad); end
      if (edges.size() >= 1) begin
         n_checks++; if (edges[0] != 6) begin n_fail++; $display("FAIL b2b_first: got %0d want 6", edges[0]); end
      end
      for (int i = 1; i < edges.size(); i++) begin
         n_checks++; if (edges[i] - edges[i-1] != W + 3) begin n_fail++; $display("FAIL b2b_period%0d: got %0d want %0d", i, edges[i] - edges[i-1], W + 3); end
      end
      settle();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_basic();
      settle();
      test_vectors();
      test_ignore_start();
      test_reset_midrun();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
